// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the lock-state type for the VGA sync decoder.
package vga_timing_pkg;

   localparam int H_ACTIVE      = 640;
   localparam int H_FRONT_PORCH = 16;
   localparam int H_SYNC_PULSE  = 96;
   localparam int H_BACK_PORCH  = 48;
   localparam int H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;

   localparam int V_ACTIVE      = 480;
   localparam int V_FRONT_PORCH = 10;
   localparam int V_SYNC_PULSE  = 2;
   localparam int V_BACK_PORCH  = 33;
   localparam int V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

   localparam int H_SYNC_START  = H_ACTIVE + H_FRONT_PORCH;
   localparam int H_SYNC_END    = H_SYNC_START + H_SYNC_PULSE;
   localparam int V_SYNC_START  = V_ACTIVE + V_FRONT_PORCH;
   localparam int V_SYNC_END    = V_SYNC_START + V_SYNC_PULSE;

   localparam int H_CNT_W       = $clog2(H_TOTAL);
   localparam int V_CNT_W       = $clog2(V_TOTAL);

   localparam int LOCK_FRAMES   = 2;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Samples one active-low sync line on pixel strobes and flags its falling/rising edges.
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic pixel_en_i,
   input  logic sync_i,
   output logic fall_o,
   output logic rise_o
);

   logic prev_q;

   // Idle level is high, so a reset with the line high never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b1;
      end else if (pixel_en_i) begin
         prev_q <= sync_i;
      end
   end

   assign fall_o = pixel_en_i & prev_q & ~sync_i;
   assign rise_o = pixel_en_i & ~prev_q & sync_i;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from incoming hSync/vSync, checks every sync edge against the
// expected timing and tracks a lock state over consecutive clean frames.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_ACT  = H_ACTIVE,
   parameter int H_FP   = H_FRONT_PORCH,
   parameter int H_SP   = H_SYNC_PULSE,
   parameter int H_BP   = H_BACK_PORCH,
   parameter int V_ACT  = V_ACTIVE,
   parameter int V_FP   = V_FRONT_PORCH,
   parameter int V_SP   = V_SYNC_PULSE,
   parameter int V_BP   = V_BACK_PORCH,
   parameter int LOCK_N = LOCK_FRAMES,
   parameter int HW     = $clog2(H_ACT + H_FP + H_SP + H_BP),
   parameter int VW     = $clog2(V_ACT + V_FP + V_SP + V_BP)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pixelEn,
   input  logic          hSync,
   input  logic          vSync,
   output logic [HW-1:0] hCount,
   output logic [VW-1:0] vCount,
   output logic          displayOn,
   output logic          locked,
   output logic          lineError,
   output logic          frameError,
   output logic          frameStart
);

   localparam logic [HW-1:0] H_LAST = HW'(H_ACT + H_FP + H_SP + H_BP - 1);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACT + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACT + H_FP + H_SP);
   localparam logic [VW-1:0] V_LAST = VW'(V_ACT + V_FP + V_SP + V_BP - 1);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACT + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACT + V_FP + V_SP);
   localparam int            GW     = $clog2(LOCK_N + 1);

   logic          h_fall, h_rise, v_fall, v_rise;
   logic [HW-1:0] h_cnt_q, h_cnt_d, h_pred;
   logic [VW-1:0] v_cnt_q, v_cnt_d, v_pred;
   logic          h_wrap, checking, line_err, frame_err;
   logic          line_err_q, line_err_d, frame_err_q, frame_err_d;
   logic          frame_start_q, frame_start_d, v_fall_q, v_fall_d;
   lock_state_t   state_q, state_d;
   logic [GW-1:0] good_q, good_d, good_inc;

   sync_edge_detect u_h_edge (
      .clk        (clk),
      .reset      (reset),
      .pixel_en_i (pixelEn),
      .sync_i     (hSync),
      .fall_o     (h_fall),
      .rise_o     (h_rise)
   );

   sync_edge_detect u_v_edge (
      .clk        (clk),
      .reset      (reset),
      .pixel_en_i (pixelEn),
      .sync_i     (vSync),
      .fall_o     (v_fall),
      .rise_o     (v_rise)
   );

   // Free-running prediction; sync falls override it, and mismatches against the prediction are errors.
   always_comb begin
      h_pred    = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
      h_wrap    = (h_pred == '0) && !h_fall;
      v_pred    = h_wrap ? ((v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1) : v_cnt_q;
      checking  = (state_q != UNLOCKED);
      line_err  = checking && ((h_fall != (h_pred == H_SS)) || (h_rise != (h_pred == H_SE)));
      frame_err = checking && (h_pred == '0) &&
                  ((v_fall != (v_pred == V_SS)) || (v_rise != (v_pred == V_SE)));

      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      line_err_d    = 1'b0;
      frame_err_d   = 1'b0;
      frame_start_d = 1'b0;
      v_fall_d      = 1'b0;
      if (pixelEn) begin
         h_cnt_d       = h_fall ? H_SS : h_pred;
         v_cnt_d       = v_fall ? V_SS : v_pred;
         line_err_d    = line_err;
         frame_err_d   = frame_err;
         frame_start_d = h_wrap && (v_cnt_q == V_LAST) && !v_fall;
         v_fall_d      = v_fall;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_start_q <= 1'b0;
         v_fall_q      <= 1'b0;
         state_q       <= UNLOCKED;
         good_q        <= '0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_err_q    <= line_err_d;
         frame_err_q   <= frame_err_d;
         frame_start_q <= frame_start_d;
         v_fall_q      <= v_fall_d;
         state_q       <= state_d;
         good_q        <= good_d;
      end
   end

   // The FSM reacts to the registered pulses, so lock changes one clock after the offending pixel.
   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      good_inc = good_q + 1'b1;
      case (state_q)
         UNLOCKED: begin
            if (v_fall_q) begin
               state_d = ACQUIRE;
               good_d  = '0;
            end
         end
         ACQUIRE: begin
            if (line_err_q || frame_err_q) begin
               state_d = UNLOCKED;
            end else if (v_fall_q) begin
               good_d = good_inc;
               if (good_inc >= GW'(LOCK_N)) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (line_err_q || frame_err_q) begin
               state_d = UNLOCKED;
            end
         end
         default: state_d = UNLOCKED;
      endcase
   end

   always_comb begin
      locked     = (state_q == LOCKED);
      displayOn  = locked && (h_cnt_q < HW'(H_ACT)) && (v_cnt_q < VW'(V_ACT));
      hCount     = h_cnt_q;
      vCount     = v_cnt_q;
      lineError  = line_err_q;
      frameError = frame_err_q;
      frameStart = frame_start_q;
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced raster so several frames fit in a short run.
module tb_vga_sync_decoder;

   localparam int HA = 16, HFP = 3, HSP = 4, HBP = 5;
   localparam int VA = 8,  VFP = 2, VSP = 2, VBP = 3;
   localparam int HT = HA + HFP + HSP + HBP;
   localparam int VT = VA + VFP + VSP + VBP;
   localparam int HSS = HA + HFP, HSE = HSS + HSP;
   localparam int VSS = VA + VFP, VSE = VSS + VSP;
   localparam int LOCKN = 2;
   localparam int HW = $clog2(HT), VW = $clog2(VT);

   logic          clk = 1'b0;
   logic          reset, pixelEn, hSync, vSync;
   logic [HW-1:0] hCount;
   logic [VW-1:0] vCount;
   logic          displayOn, locked, lineError, frameError, frameStart;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_ACT(HA), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
      .V_ACT(VA), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP),
      .LOCK_N(LOCKN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pixelEn    (pixelEn),
      .hSync      (hSync),
      .vSync      (vSync),
      .hCount     (hCount),
      .vCount     (vCount),
      .displayOn  (displayOn),
      .locked     (locked),
      .lineError  (lineError),
      .frameError (frameError),
      .frameStart (frameStart)
   );

   typedef struct {
      int cyc;
      int h;
      int v;
      bit de, lk, le, fe, fs;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   checks = 0, errors = 0;
   int   obs_le = 0, obs_fe = 0;
   bit   rand_gaps = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: position is "last sync fall plus pixels since", lock is a count of clean frames.
   int m_h, m_v, m_lock, m_good;
   bit m_hp, m_vp, m_le, m_fe, m_fs, m_vfall;

   task automatic model_step(input bit r, input bit en, input bit hs, input bit vs);
      exp_t e;
      int   old_lock, p, nv;
      bit   hf, hr, vf, vr, wrapped;
      if (r) begin
         m_h = 0; m_v = 0; m_hp = 1; m_vp = 1; m_lock = 0; m_good = 0;
         m_le = 0; m_fe = 0; m_fs = 0; m_vfall = 0;
      end else begin
         old_lock = m_lock;
         if (m_lock != 0 && (m_le || m_fe)) m_lock = 0;
         else if (m_vfall) begin
            if (m_lock == 0) begin
               m_lock = 1; m_good = 0;
            end else if (m_lock == 1) begin
               m_good++;
               if (m_good >= LOCKN) m_lock = 2;
            end
         end
         m_le = 0; m_fe = 0; m_fs = 0; m_vfall = 0;
         if (en) begin
            hf = m_hp && !hs; hr = !m_hp && hs;
            vf = m_vp && !vs; vr = !m_vp && vs;
            p = (m_h + 1) % HT;
            wrapped = (p == 0) && !hf;
            nv = wrapped ? (m_v + 1) % VT : m_v;
            if (old_lock != 0) begin
               m_le = (hf != (p == HSS)) || (hr != (p == HSE));
               if (p == 0) m_fe = (vf != (nv == VSS)) || (vr != (nv == VSE));
            end
            m_fs = wrapped && (m_v == VT - 1) && !vf;
            m_h = hf ? HSS : p;
            m_v = vf ? VSS : nv;
            m_vfall = vf;
            m_hp = hs; m_vp = vs;
         end
      end
      e.cyc = cyc + 1;
      e.h = m_h; e.v = m_v;
      e.lk = (m_lock == 2);
      e.de = e.lk && (m_h < HA) && (m_v < VA);
      e.le = m_le; e.fe = m_fe; e.fs = m_fs;
      sb_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: one line per clock, compares whatever expectation targets this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (lineError) obs_le++;
         if (frameError) obs_fe++;
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc != cyc || int'(hCount) != e.h || int'(vCount) != e.v || displayOn != e.de ||
                locked != e.lk || lineError != e.le || frameError != e.fe || frameStart != e.fs) begin
               errors++;
               $display("FAIL sb cyc=%0d: got h=%0d v=%0d de=%0b lk=%0b le=%0b fe=%0b fs=%0b expected h=%0d v=%0d de=%0b lk=%0b le=%0b fe=%0b fs=%0b",
                        cyc, hCount, vCount, displayOn, locked, lineError, frameError, frameStart,
                        e.h, e.v, e.de, e.lk, e.le, e.fe, e.fs);
            end
         end
      end
   end

   task automatic drive(input bit r, input bit en, input bit hs, input bit vs);
      reset = r; pixelEn = en; hSync = hs; vSync = vs;
      model_step(r, en, hs, vs);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic run_frame(input int skip_line, input int narrow_line, input bit short_frame,
                            input int gap_line, input int rst_line);
      bit hs, vs;
      for (int v = 0; v < VT; v++) begin
         if (short_frame && v == 3) continue;
         for (int h = 0; h < HT; h++) begin
            hs = !(h >= HSS && h < HSE);
            if (v == skip_line) hs = 1'b1;
            if (v == narrow_line && h == HSE - 1) hs = 1'b1;
            vs = !(v >= VSS && v < VSE);
            if (v == gap_line && h == 10) idle(100);
            if (rand_gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive(v == rst_line && h == 8, 1'b1, hs, vs);
         end
      end
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) run_frame(-1, -1, 1'b0, -1, -1);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; pixelEn = 1'b0; hSync = 1'b1; vSync = 1'b1;
      repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1);

      clean(4);
      settle(); check("lock_after_clean", locked, 1);

      obs_le = 0; obs_fe = 0;
      run_frame(4, -1, 1'b0, -1, -1);
      settle(); check("skip_hsync_lineerr", obs_le, 1); check("skip_hsync_unlock", locked, 0);
      clean(2);
      settle(); check("relock_after_skip", locked, 1);

      rand_gaps = 1'b0; obs_le = 0; obs_fe = 0;
      run_frame(-1, 2, 1'b0, -1, -1);
      rand_gaps = 1'b1;
      settle(); check("narrow_hsync_lineerr", obs_le, 2); check("narrow_hsync_unlock", locked, 0);
      clean(2);
      settle(); check("relock_after_narrow", locked, 1);

      obs_le = 0; obs_fe = 0;
      run_frame(-1, -1, 1'b1, -1, -1);
      settle(); check("short_frame_frameerr", obs_fe, 1); check("short_frame_unlock", locked, 0);
      clean(3);
      settle(); check("relock_after_short", locked, 1);

      obs_le = 0; obs_fe = 0;
      run_frame(-1, -1, 1'b0, 6, -1);
      settle(); check("gap_keeps_lock", locked, 1); check("gap_no_errors", obs_le + obs_fe, 0);

      run_frame(-1, -1, 1'b0, -1, 5);
      settle(); check("reset_midframe_unlocked", locked, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA sync generators: samples incoming active-low hSync/vSync on pixel strobes, recovers the horizontal/vertical pixel position, and checks every sync edge against 640x480@60 timing (800x525 total). It sits downstream of any VGA timing source (own generator in loopback, or an external video port) and feeds consumers that need position, display-enable and a lock flag.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT_PORCH, 16; H_SYNC_PULSE, 96; H_BACK_PORCH, 48 (H_TOTAL = 800)
- V_ACTIVE, 480; V_FRONT_PORCH, 10; V_SYNC_PULSE, 2; V_BACK_PORCH, 33 (V_TOTAL = 525)
- LOCK_FRAMES, 2, consecutive error-free frames required to declare lock
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- pixelEn  in  1  one-clock strobe per pixel; all sampling/counting only on pixelEn=1
- hSync  in  1  horizontal sync, active low, synchronous to clk
- vSync  in  1  vertical sync, active low, synchronous to clk
- hCount  out  $clog2(800)  recovered pixel column
- vCount  out  $clog2(525)  recovered line
- displayOn  out  1  locked && hCount<H_ACTIVE && vCount<V_ACTIVE
- locked  out  1  lock state is LOCKED
- lineError  out  1  one-clock pulse: horizontal edge mismatch
- frameError  out  1  one-clock pulse: vertical edge mismatch
- frameStart  out  1  one-clock pulse when vCount wraps V_TOTAL-1 -> 0

## Operation
- hSyncPrev/vSyncPrev registers updated on pixelEn; fall = prev 1 & now 0, rise = prev 0 & now 1.
- Horizontal: predicted column p = hCount+1 (wrap 799->0). On hSync fall, hCount <= 656 (H_ACTIVE+H_FRONT_PORCH) regardless of p; else hCount <= p.
- Vertical: increments on horizontal wrap (799->0), wrap 524->0. On vSync fall, vCount <= 490; realign takes priority over increment in the same cycle.
- Checks (evaluated on pixelEn, only outside UNLOCKED): hSync fall with p!=656, or p==656 with no fall -> lineError; hSync rise with p!=752, or p==752 with no rise -> lineError. vSync edges checked only on pixels with p==0: fall expected at new vCount 490, rise at 492; mismatch either way -> frameError.
- Lock FSM: UNLOCKED -> ACQUIRE on first vSync fall (goodFrames=0). ACQUIRE: each vSync fall with no error since previous fall increments goodFrames; reaching LOCK_FRAMES -> LOCKED; any error -> UNLOCKED. LOCKED: any lineError/frameError -> UNLOCKED.
- In UNLOCKED counters still free-run and realign on edges; no error pulses.
- Simultaneous h and v edges on one pixel: both realigns apply; both errors may pulse.

## Timing
- Latency: counters/flags reflect the pixel sampled on the previous clock (1 clk).
- Error pulses coincide with the counter update for the offending pixel; locked deasserts on the following clock.
- frameStart asserts in the clock where vCount becomes 0.
- pixelEn=0: all state holds, no pulses.
- Reset values: hCount 0, vCount 0, displayOn 0, locked 0, lineError 0, frameError 0, frameStart 0, hSyncPrev 1, vSyncPrev 1, state UNLOCKED, goodFrames 0. Reset mid-frame takes effect next clock; no spurious edge after release with syncs high.

## Structure
- vga_timing_pkg: all H_*/V_* localparams, H_TOTAL/V_TOTAL, count widths, sync start/end constants (656, 752, 490, 492), lock state enum (UNLOCKED, ACQUIRE, LOCKED).
- Sub-module sync_edge_detect (prev register + rise/fall pulses gated by pixelEn), instantiated for hSync and vSync.

## Test plan
- Reset, drive clean 800x525 stream (pixelEn every clk): locked asserts the clock after the 3rd vSync fall; thereafter hCount/vCount equal source counters delayed 1 clk, no errors.
- While locked, suppress hSync pulse on line 100: lineError at p=656, locked=0 next clk; relocks after 3 further clean vSync falls.
- hSync pulse 95 pixels wide (rise at 751): lineError at 751 and at 752; unlock.
- Frame of 524 lines (vSync falls at predicted vCount 489): frameError, vCount realigned to 490, unlock.
- Assert reset at hCount 300, vCount 200 for 1 clk: all outputs 0 next clk, no edge pulses with syncs high.
- pixelEn low 100 clks mid-line while locked: counters hold, no errors, lock retained.
